data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 110 +++++++++++
 1 files changed

// File: rtl/data_cache.sv
// Direct-mapped 16-line write-back, write-allocate data cache.
// Zero-latency hits; misses stall through optional writeback then fill.
module data_cache (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        stall,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_wrt_data,
    input  logic [15:0] mem_rd_data,
    input  logic        mem_rdy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] data_q [16];
    logic [11:0] tag_q  [16];
    logic [15:0] valid_q;
    logic [15:0] dirty_q;

    logic [3:0]  idx;
    logic [11:0] tag_in;
    logic        req;
    logic        hit;
    logic        victim_dirty;
    logic        in_idle;

    assign idx          = addr[3:0];
    assign tag_in       = addr[15:4];
    assign req          = re | we;
    assign hit          = req & valid_q[idx] & (tag_q[idx] == tag_in);
    assign victim_dirty = valid_q[idx] & dirty_q[idx];
    assign in_idle      = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit && we) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (req && !hit) begin
                        state_q <= victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_rdy) begin
                        dirty_q[idx] <= 1'b0;
                        state_q      <= FILL;
                    end
                end
                FILL: begin
                    if (mem_rdy) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line storage is deliberately unreset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (in_idle && hit && we) begin
            data_q[idx] <= wrt_data;
        end else if (state_q == FILL && mem_rdy) begin
            data_q[idx] <= mem_rd_data;
            tag_q[idx]  <= tag_in;
        end
    end

    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            stall = in_idle ? (req & ~hit) : 1'b1;
        end
    end

    assign rd_data = (in_idle && re && hit) ? data_q[idx] : 16'h0000;

    assign mem_we       = (state_q == WRITEBACK);
    assign mem_re       = (state_q == FILL);
    assign mem_wrt_data = mem_we ? data_q[idx] : 16'h0000;

    always_comb begin
        mem_addr = 16'h0000;
        if (mem_we) begin
            mem_addr = {tag_q[idx], idx};
        end else if (mem_re) begin
            mem_addr = addr;
        end
    end

endmodule
